i2s_tdm_transceiver: RTL and testbench

- Parametrised successor to the single-frame SGTL5000 PCM exchanger: slave-mode serial audio transceiver for CHANNELS time-division slots of SLOT_BITS each, carrying SAMPLE_BITS MSB-justified samples.
- Supports a DSP-mode one-SCLK sync pulse or I2S 50% LRCLK framing, with a TX holding register handshake, an RX strobe, and frame-error/underrun reporting.
- Sits between the codec pads (after SB_IO input registers) and the SID audio mixer/filter path.

---
 rtl/i2s_pkg.sv | 27 ++
 rtl/i2s_edge_sync.sv | 45 ++++
 rtl/i2s_tdm_transceiver.sv | 169 ++++++++++++++++
 tb/tb_i2s_tdm_transceiver.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and helpers for the TDM/I2S serial audio transceiver.
//   sync_mode_t   : frame-sync flavour (DSP one-SCLK pulse or I2S 50% LRCLK)
//   frame_bits()  : serial bits per frame
//   cnt_width()   : width of a bit counter that must also hold the idle value
//   is_sample_bit : true when a slot-local bit position carries sample data
package i2s_pkg;

    typedef enum logic {
        SYNC_PULSE = 1'b0,
        SYNC_LEVEL = 1'b1
    } sync_mode_t;

    function automatic int frame_bits(input int channels, input int slot_bits);
        return channels * slot_bits;
    endfunction

    // The counters park at FRAME_BITS when idle, so they need one extra code.
    function automatic int cnt_width(input int channels, input int slot_bits);
        return $clog2(channels * slot_bits + 1);
    endfunction

    // Samples are MSB-justified: the first sample_bits positions of a slot are data.
    function automatic logic is_sample_bit(input int slot_pos, input int sample_bits);
        return (slot_pos < sample_bits);
    endfunction

endpackage

// File: rtl/i2s_edge_sync.sv
// Retiming stage for the codec serial interface.
//   clk, rst            : system clock, asynchronous active-high reset
//   i_lrclk, i_sclk,
//   i_sd                : pad-registered codec signals
//   o_lrclk, o_sd       : the same signals one clk later, aligned with the strobes
//   o_sclk_rise/fall    : single-clk strobes on SCLK edges
module i2s_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_lrclk,
    input  logic i_sclk,
    input  logic i_sd,
    output logic o_lrclk,
    output logic o_sd,
    output logic o_sclk_rise,
    output logic o_sclk_fall
);

    logic r_lrclk;
    logic r_sclk;
    logic r_sclk_d;
    logic r_sd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lrclk  <= 1'b0;
            r_sclk   <= 1'b0;
            r_sclk_d <= 1'b0;
            r_sd     <= 1'b0;
        end else begin
            r_lrclk  <= i_lrclk;
            r_sclk   <= i_sclk;
            r_sclk_d <= r_sclk;
            r_sd     <= i_sd;
        end
    end

    // lrclk and sd share the sclk register stage, so at a strobe they show
    // the values the codec presented at that SCLK edge.
    assign o_lrclk     = r_lrclk;
    assign o_sd        = r_sd;
    assign o_sclk_rise = r_sclk & ~r_sclk_d;
    assign o_sclk_fall = ~r_sclk & r_sclk_d;

endmodule

// File: rtl/i2s_tdm_transceiver.sv
// Slave-mode TDM / I2S serial audio transceiver.
//   clk, rst       : system clock, asynchronous active-high reset
//   i2s_lrclk/sclk : frame sync and bit clock from the codec
//   i2s_sd_in      : ADC serial data;  i2s_sd_out : DAC serial data
//   tx_data/valid  : samples to send (slot 0 in MSBs); tx_ready = holding reg empty
//   rx_data/valid  : last complete received frame, rx_valid pulses on update
//   frame_err      : pulse when a new frame starts before the previous completed
//   underrun       : pulse when a frame starts with no TX word held
module i2s_tdm_transceiver
    import i2s_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int SLOT_BITS   = 32,
    parameter int SAMPLE_BITS = 24,
    parameter int SYNC_MODE   = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i2s_lrclk,
    input  logic                            i2s_sclk,
    input  logic                            i2s_sd_in,
    output logic                            i2s_sd_out,
    input  logic [CHANNELS*SAMPLE_BITS-1:0] tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic [CHANNELS*SAMPLE_BITS-1:0] rx_data,
    output logic                            rx_valid,
    output logic                            frame_err,
    output logic                            underrun
);

    localparam int FRAME_BITS = frame_bits(CHANNELS, SLOT_BITS);
    localparam int CNTW       = cnt_width(CHANNELS, SLOT_BITS);
    localparam int DW         = CHANNELS * SAMPLE_BITS;
    localparam int SLW        = $clog2(SLOT_BITS);

    logic w_lrclk, w_sd, w_sclk_rise, w_sclk_fall;
    logic w_lr_edge, w_start;

    i2s_edge_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_lrclk    (i2s_lrclk),
        .i_sclk     (i2s_sclk),
        .i_sd       (i2s_sd_in),
        .o_lrclk    (w_lrclk),
        .o_sd       (w_sd),
        .o_sclk_rise(w_sclk_rise),
        .o_sclk_fall(w_sclk_fall)
    );

    logic r_lr_prev;

    // DSP mode frames on the sync pulse rising; I2S frames on LRCLK falling (left first).
    assign w_lr_edge = (SYNC_MODE == int'(SYNC_LEVEL)) ? (r_lr_prev & ~w_lrclk)
                                                       : (~r_lr_prev & w_lrclk);
    assign w_start   = w_sclk_rise & w_lr_edge;

    // ---------------- receive path ----------------
    logic [CNTW-1:0] r_rx_cnt;
    logic [SLW-1:0]  r_rx_pos;
    logic [DW-1:0]   r_rx_sh;
    logic [DW-1:0]   r_rx_data;
    logic            r_rx_valid;
    logic            r_frame_err;
    logic            w_rx_take, w_rx_keep, w_rx_last;
    logic [DW-1:0]   w_rx_next;

    assign w_rx_take = w_sclk_rise & ~w_start & (r_rx_cnt < CNTW'(FRAME_BITS));
    assign w_rx_keep = is_sample_bit(int'(r_rx_pos), SAMPLE_BITS);
    assign w_rx_last = w_rx_take & (r_rx_cnt == CNTW'(FRAME_BITS - 1));
    // Only sample bits enter the shifter, so a full frame fills it exactly and
    // leftovers from a dropped short frame are pushed out.
    assign w_rx_next = w_rx_keep ? {r_rx_sh[DW-2:0], w_sd} : r_rx_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lr_prev   <= 1'b0;
            r_rx_cnt    <= CNTW'(FRAME_BITS);
            r_rx_pos    <= '0;
            r_rx_sh     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_sclk_rise) begin
                r_lr_prev <= w_lrclk;
            end
            if (w_start) begin
                r_frame_err <= (r_rx_cnt != '0) && (r_rx_cnt < CNTW'(FRAME_BITS));
                r_rx_cnt    <= '0;
                r_rx_pos    <= '0;
            end else if (w_rx_take) begin
                r_rx_sh  <= w_rx_next;
                r_rx_cnt <= r_rx_cnt + 1'b1;
                r_rx_pos <= (r_rx_pos == SLW'(SLOT_BITS - 1)) ? '0 : r_rx_pos + 1'b1;
                if (w_rx_last) begin
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                end
            end
        end
    end

    // ---------------- transmit path ----------------
    logic [DW-1:0]   r_hold;
    logic            r_hold_full;
    logic [DW-1:0]   r_tx_sh;
    logic [CNTW-1:0] r_tx_cnt;
    logic [SLW-1:0]  r_tx_pos;
    logic            r_sd_out;
    logic            r_underrun;
    logic            w_load, w_tx_keep;

    assign w_load    = tx_valid & ~r_hold_full;
    assign w_tx_keep = is_sample_bit(int'(r_tx_pos), SAMPLE_BITS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_tx_sh     <= '0;
            r_tx_cnt    <= CNTW'(FRAME_BITS);
            r_tx_pos    <= '0;
            r_sd_out    <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_start) begin
                r_tx_cnt <= '0;
                r_tx_pos <= '0;
                if (r_hold_full) begin
                    r_tx_sh     <= r_hold;
                    r_hold_full <= 1'b0;
                end else begin
                    r_tx_sh    <= '0;
                    r_underrun <= 1'b1;
                end
            end else if (w_sclk_fall) begin
                if (r_tx_cnt < CNTW'(FRAME_BITS)) begin
                    r_sd_out <= w_tx_keep ? r_tx_sh[DW-1] : 1'b0;
                    if (w_tx_keep) begin
                        r_tx_sh <= {r_tx_sh[DW-2:0], 1'b0};
                    end
                    r_tx_cnt <= r_tx_cnt + 1'b1;
                    r_tx_pos <= (r_tx_pos == SLW'(SLOT_BITS - 1)) ? '0 : r_tx_pos + 1'b1;
                end else begin
                    r_sd_out <= 1'b0;
                end
            end
            // Placed last: a load coinciding with a frame start is kept for the
            // next frame, since the start decision used the old empty state.
            if (w_load) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    assign i2s_sd_out = r_sd_out;
    assign tx_ready   = ~r_hold_full;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign frame_err  = r_frame_err;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_i2s_tdm_transceiver.sv
`timescale 1ns/1ps
module tb_i2s_tdm_transceiver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sclk;
    logic [2:0]  lr;
    logic [2:0]  sdi;
    logic [2:0]  txv;
    logic [47:0] tx_data;
    wire  [2:0]  sdo, rdy, rxv, ferr, urun;
    wire  [47:0] rxd0, rxd1, rxd2;

    // dut0: default DSP pulse, dut1: I2S level, dut2: 4x16-bit slots carrying 12-bit samples
    i2s_tdm_transceiver dut0 (
        .clk(clk), .rst(rst), .i2s_lrclk(lr[0]), .i2s_sclk(sclk), .i2s_sd_in(sdi[0]),
        .i2s_sd_out(sdo[0]), .tx_data(tx_data), .tx_valid(txv[0]), .tx_ready(rdy[0]),
        .rx_data(rxd0), .rx_valid(rxv[0]), .frame_err(ferr[0]), .underrun(urun[0]));

    i2s_tdm_transceiver #(.SYNC_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .i2s_lrclk(lr[1]), .i2s_sclk(sclk), .i2s_sd_in(sdi[1]),
        .i2s_sd_out(sdo[1]), .tx_data(tx_data), .tx_valid(txv[1]), .tx_ready(rdy[1]),
        .rx_data(rxd1), .rx_valid(rxv[1]), .frame_err(ferr[1]), .underrun(urun[1]));

    i2s_tdm_transceiver #(.CHANNELS(4), .SLOT_BITS(16), .SAMPLE_BITS(12)) dut2 (
        .clk(clk), .rst(rst), .i2s_lrclk(lr[2]), .i2s_sclk(sclk), .i2s_sd_in(sdi[2]),
        .i2s_sd_out(sdo[2]), .tx_data(tx_data), .tx_valid(txv[2]), .tx_ready(rdy[2]),
        .rx_data(rxd2), .rx_valid(rxv[2]), .frame_err(ferr[2]), .underrun(urun[2]));

    int total = 0;
    int bad   = 0;
    int nferr [3] = '{default: 0};
    int nur   [3] = '{default: 0};
    logic [47:0] q0[$], q1[$], q2[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, expv);
        end
    endtask

    task automatic push_rx(input int sel, input logic [47:0] w);
        if (sel == 0) q0.push_back(w);
        else if (sel == 1) q1.push_back(w);
        else q2.push_back(w);
    endtask

    function automatic int qsize(input int sel);
        return (sel == 0) ? q0.size() : (sel == 1) ? q1.size() : q2.size();
    endfunction

    task automatic rx_pop(input int sel, input logic [47:0] got);
        logic [47:0] e;
        int n;
        n = qsize(sel);
        total++;
        assert (n != 0) else begin
            bad++;
            $error("FAIL rx_unexpected_valid dut%0d got=%h exp=no pulse", sel, got);
        end
        if (n != 0) begin
            if (sel == 0) e = q0.pop_front();
            else if (sel == 1) e = q1.pop_front();
            else e = q2.pop_front();
            check($sformatf("rx_data_dut%0d", sel), {80'd0, got}, {80'd0, e});
        end
    endtask

    // Scoreboard side: every rx_valid pulse consumes one expected frame.
    always @(negedge clk) begin
        if (rxv[0]) rx_pop(0, rxd0);
        if (rxv[1]) rx_pop(1, rxd1);
        if (rxv[2]) rx_pop(2, rxd2);
        for (int i = 0; i < 3; i++) begin
            if (ferr[i]) nferr[i]++;
            if (urun[i]) nur[i]++;
        end
    end

    // Serial bit j of a frame (bit j of the result): MSB-justified samples, pad elsewhere.
    function automatic logic [127:0] stream(input logic [47:0] w, input int fb, input int slot,
                                            input int samp, input logic padv);
        logic [127:0] s;
        int sl, p;
        s = '0;
        for (int j = 0; j < fb; j++) begin
            sl = j / slot;
            p  = j % slot;
            s[j] = (p < samp) ? w[47 - (sl * samp + p)] : padv;
        end
        return s;
    endfunction

    task automatic load_tx(input int sel, input logic [47:0] w);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!rdy[sel] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("tx_ready_before_load_dut%0d", sel), {127'd0, rdy[sel]}, 128'd1);
        tx_data  = w;
        txv[sel] = 1'b1;
        @(negedge clk);
        txv[sel] = 1'b0;
        check($sformatf("tx_ready_after_load_dut%0d", sel), {127'd0, rdy[sel]}, 128'd0);
    endtask

    // One frame of nclk SCLK periods: k=0 carries the frame start, k=1..fb data, rest padding.
    // Codec side drives on SCLK fall and samples sd_out just before SCLK rise.
    task automatic run_frame(input int sel, input int mode, input int nclk, input int fb,
                             input int slot, input int samp, input logic [47:0] rxw,
                             input logic padv, input logic [47:0] txw, input bit txchk,
                             input bit sc_load, input logic [47:0] scw, input string tag);
        logic [127:0] rs, ts, got, expv;
        rs   = stream(rxw, fb, slot, samp, padv);
        ts   = stream(txw, fb, slot, samp, 1'b0);
        got  = '0;
        expv = '0;
        for (int k = 0; k < nclk; k++) begin
            @(negedge clk);
            sclk    = 1'b0;
            lr[sel] = (mode == 1) ? (k >= slot) : (k == 0);
            sdi[sel] = (k >= 1 && k <= fb) ? rs[k-1] : padv;
            repeat (3) @(negedge clk);
            if (k >= 1) begin
                got[k-1]  = sdo[sel];
                expv[k-1] = (k <= fb) ? ts[k-1] : 1'b0;
            end
            @(negedge clk);
            sclk = 1'b1;
            if (k == 0 && sc_load) begin
                // tx_valid lands in the clk that acts on the frame start
                @(negedge clk);
                tx_data  = scw;
                txv[sel] = 1'b1;
                @(negedge clk);
                txv[sel] = 1'b0;
                repeat (2) @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
        end
        if (txchk) check(tag, got, expv);
    endtask

    int ur0;

    initial begin
        rst = 1'b1; sclk = 1'b0; lr = 3'b010; sdi = 3'b000; txv = 3'b000; tx_data = '0;
        repeat (3) @(negedge clk);
        check("reset_tx_ready", {125'd0, rdy}, 128'd7);
        check("reset_sd_out",   {125'd0, sdo}, 128'd0);
        check("reset_pulses",   {119'd0, rxv, ferr, urun}, 128'd0);
        check("reset_rx_data",  {80'd0, rxd0}, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // DSP frame with the reference values
        load_tx(0, 48'hABCDEF_123456);
        push_rx(0, 48'hA5A5A5_5A5A5A);
        run_frame(0, 0, 65, 64, 32, 24, 48'hA5A5A5_5A5A5A, 1'b0, 48'hABCDEF_123456, 1, 0, '0, "t1_sd_out");
        check("t1_rx_arrived", qsize(0), 0);
        check("t1_tx_ready_after_start", {127'd0, rdy[0]}, 128'd1);
        check("t1_no_underrun", nur[0], 0);
        check("t1_no_frame_err", nferr[0], 0);

        // slot padding driven as ones must be discarded
        load_tx(0, 48'h0F0F0F_F0F0F0);
        push_rx(0, 48'h123456_789ABC);
        run_frame(0, 0, 65, 64, 32, 24, 48'h123456_789ABC, 1'b1, 48'h0F0F0F_F0F0F0, 1, 0, '0, "t2_sd_out");
        check("t2_rx_arrived", qsize(0), 0);

        // short frame: 40 of 64 bits, then a full frame
        load_tx(0, 48'hC3C3C3_3C3C3C);
        run_frame(0, 0, 41, 64, 32, 24, 48'hFFFFFF_FFFFFF, 1'b1, '0, 0, 0, '0, "t3_partial");
        check("t3_rx_unchanged", {80'd0, rxd0}, {80'd0, 48'h123456_789ABC});
        check("t3_no_err_yet", nferr[0], 0);
        load_tx(0, 48'h5A5A5A_A5A5A5);
        push_rx(0, 48'h13579B_DF2468);
        run_frame(0, 0, 65, 64, 32, 24, 48'h13579B_DF2468, 1'b0, 48'h5A5A5A_A5A5A5, 1, 0, '0, "t3_sd_out");
        check("t3_frame_err_once", nferr[0], 1);
        check("t3_rx_arrived", qsize(0), 0);

        // underrun, with a word offered in the frame-start clk
        ur0 = nur[0];
        push_rx(0, 48'hFEDCBA_987654);
        run_frame(0, 0, 65, 64, 32, 24, 48'hFEDCBA_987654, 1'b0, '0, 1, 1, 48'h876543_210FED, "t4_zero_out");
        check("t4_underrun_pulse", nur[0], ur0 + 1);
        check("t4_word_held", {127'd0, rdy[0]}, 128'd0);
        push_rx(0, 48'h000FFF_FFF000);
        run_frame(0, 0, 65, 64, 32, 24, 48'h000FFF_FFF000, 1'b1, 48'h876543_210FED, 1, 0, '0, "t4_next_frame");
        check("t4_no_second_underrun", nur[0], ur0 + 1);
        check("t4_rx_arrived", qsize(0), 0);

        // I2S framing: left slot while LRCLK low
        load_tx(1, 48'hC0FFEE_123ABC);
        push_rx(1, 48'hA1B2C3_D4E5F6);
        run_frame(1, 1, 66, 64, 32, 24, 48'hA1B2C3_D4E5F6, 1'b1, 48'hC0FFEE_123ABC, 1, 0, '0, "t5_i2s_sd_out");
        check("t5_rx_arrived", qsize(1), 0);
        check("t5_no_underrun", nur[1], 0);
        check("t5_no_frame_err", nferr[1], 0);

        // 4 channels, 12-bit samples in 16-bit slots, 32 padding SCLKs per frame
        load_tx(2, 48'hABC123_456DEF);
        push_rx(2, 48'h5A5A5A_F0F0F0);
        run_frame(2, 0, 97, 64, 16, 12, 48'h5A5A5A_F0F0F0, 1'b1, 48'hABC123_456DEF, 1, 0, '0, "t6_sd_out_f1");
        check("t6_rx_f1", qsize(2), 0);
        load_tx(2, 48'h000FFF_800001);
        push_rx(2, 48'h123456_789ABC);
        run_frame(2, 0, 97, 64, 16, 12, 48'h123456_789ABC, 1'b1, 48'h000FFF_800001, 1, 0, '0, "t6_sd_out_f2");
        check("t6_rx_f2", qsize(2), 0);
        check("t6_no_frame_err", nferr[2], 0);

        // reset in the middle of a frame
        load_tx(0, 48'hFFFFFF_FFFFFF);
        run_frame(0, 0, 40, 64, 32, 24, 48'h0, 1'b0, '0, 0, 0, '0, "t7_partial");
        check("t7_midframe_sd_out", {127'd0, sdo[0]}, 128'd1);
        load_tx(0, 48'h2468AC_E13579);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t7_async_sd_out", {127'd0, sdo[0]}, 128'd0);
        check("t7_async_tx_ready", {127'd0, rdy[0]}, 128'd1);
        check("t7_async_rx_data", {80'd0, rxd0}, 128'd0);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        sclk = 1'b0;
        check("t7_no_rx_valid", {127'd0, rxv[0]}, 128'd0);
        ur0 = nur[0];
        load_tx(0, 48'h2468AC_E13579);
        push_rx(0, 48'h987654_3210AB);
        run_frame(0, 0, 65, 64, 32, 24, 48'h987654_3210AB, 1'b0, 48'h2468AC_E13579, 1, 0, '0, "t7_after_reset");
        check("t7_rx_arrived", qsize(0), 0);
        check("t7_no_underrun", nur[0], ur0);
        check("t7_no_frame_err", nferr[0], 1);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
